// File: rtl/guess_pkg.sv
// Shared types and constants for the guess-number judge.
// LOCKED only exists when GUESS_TRY_LIMIT_EN is defined.
package guess_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    COMPARE,
    RESULT,
    WIN
`ifdef GUESS_TRY_LIMIT_EN
    , LOCKED
`endif
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  localparam logic [1:0] HINT_NONE = 2'b00;
  localparam logic [1:0] HINT_LOW  = 2'b01;
  localparam logic [1:0] HINT_HIGH = 2'b10;

  // Two conditional subtractions are enough because an 8-bit value is below 300.
  function automatic logic [6:0] mod100(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (r >= 8'd200) r = r - 8'd200;
    if (r >= 8'd100) r = r - 8'd100;
    return 7'(r);
  endfunction

endpackage

// File: rtl/guess_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that free-runs every cycle.
module guess_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_div,
  input  logic       rst,
  output logic [7:0] state
);

  always_ff @(posedge clk_div) begin
    if (!rst) state <= SEED;
    else      state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
  end

endmodule

// File: rtl/guess_judge.sv
// Two-digit guess entry, format check and compare against an LFSR-drawn answer.
// Optional try-limit lockout is compiled in with GUESS_TRY_LIMIT_EN.
module guess_judge
  import guess_pkg::*;
#(
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter int unsigned MAX_TRIES = 7
) (
  input  logic       clk_div,
  input  logic       rst,
  input  logic       new_game,
  input  logic       preset_valid,
  input  logic [6:0] preset_ans,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       in_correct,
  output logic       ans_correct,
  output logic       result_valid,
  output logic [1:0] hint,
  output logic [7:0] guess_bcd,
  output logic [3:0] tries,
  output logic       game_over,
  output state_t     state
);

  logic [7:0] lfsr_q;
  logic [6:0] ans;
  logic [1:0] cnt;
  logic       ovf;

  logic [1:0] key_cnt, base_cnt;
  logic       key_ovf, base_ovf;
  logic [7:0] key_bcd, base_bcd;
  logic [6:0] guess_val, answer_cap;
  logic [3:0] tries_inc;
  logic       entry_ok;

  guess_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_div (clk_div),
    .rst     (rst),
    .state   (lfsr_q)
  );

`ifdef GUESS_TRY_LIMIT_EN
  localparam logic [3:0] MAX_TRIES_4 = 4'(MAX_TRIES);
  logic over_q;
  assign game_over = over_q;
`else
  logic unused_max_tries;
  assign unused_max_tries = ^(4'(MAX_TRIES));
  assign game_over = 1'b0;
`endif

  // Key effect on the entry; in RESULT the entry is cleared before the key lands.
  always_comb begin
    base_cnt = (state == RESULT) ? 2'd0 : cnt;
    base_ovf = (state == RESULT) ? 1'b0 : ovf;
    base_bcd = (state == RESULT) ? 8'h00 : guess_bcd;
    key_cnt  = base_cnt;
    key_ovf  = base_ovf;
    key_bcd  = base_bcd;
    if (key_code <= 4'd9) begin
      case (base_cnt)
        2'd0:    begin key_bcd = {key_code, base_bcd[3:0]}; key_cnt = 2'd1; end
        2'd1:    begin key_bcd = {base_bcd[7:4], key_code}; key_cnt = 2'd2; end
        default: key_ovf = 1'b1;
      endcase
    end else if (key_code == KEY_CLEAR) begin
      key_cnt = 2'd0;
      key_ovf = 1'b0;
      key_bcd = 8'h00;
    end
  end

  always_comb begin
    guess_val  = 7'(guess_bcd[7:4]) * 7'd10 + 7'(guess_bcd[3:0]);
    entry_ok   = (cnt == 2'd2) && !ovf;
    tries_inc  = (tries == 4'hF) ? 4'hF : tries + 4'd1;
    answer_cap = preset_valid ? ((preset_ans > 7'd99) ? 7'd99 : preset_ans)
                              : mod100(lfsr_q);
  end

  always_ff @(posedge clk_div) begin
    if (!rst) begin
      state        <= IDLE;
      ans          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      guess_bcd    <= '0;
      tries        <= '0;
      in_correct   <= 1'b0;
      ans_correct  <= 1'b0;
      result_valid <= 1'b0;
      hint         <= HINT_NONE;
`ifdef GUESS_TRY_LIMIT_EN
      over_q       <= 1'b0;
`endif
    end else if (new_game) begin
      state        <= ENTRY;
      ans          <= answer_cap;
      cnt          <= '0;
      ovf          <= 1'b0;
      guess_bcd    <= '0;
      tries        <= '0;
      in_correct   <= 1'b0;
      ans_correct  <= 1'b0;
      result_valid <= 1'b0;
      hint         <= HINT_NONE;
`ifdef GUESS_TRY_LIMIT_EN
      over_q       <= 1'b0;
`endif
    end else begin
      case (state)
        ENTRY: begin
          if (key_valid) begin
            if (key_code == KEY_ENTER) begin
              state <= COMPARE;
            end else begin
              cnt       <= key_cnt;
              ovf       <= key_ovf;
              guess_bcd <= key_bcd;
            end
          end
        end
        COMPARE: begin
          result_valid <= 1'b1;
          if (entry_ok) begin
            in_correct  <= 1'b1;
            tries       <= tries_inc;
            ans_correct <= (guess_val == ans);
            hint        <= (guess_val < ans) ? HINT_LOW :
                           (guess_val > ans) ? HINT_HIGH : HINT_NONE;
            if (guess_val == ans) begin
              state <= WIN;
            end else begin
              state <= RESULT;
`ifdef GUESS_TRY_LIMIT_EN
              if (tries_inc == MAX_TRIES_4) begin
                state  <= LOCKED;
                over_q <= 1'b1;
              end
`endif
            end
          end else begin
            in_correct  <= 1'b0;
            ans_correct <= 1'b0;
            hint        <= HINT_NONE;
            state       <= RESULT;
          end
        end
        RESULT: begin
          // Enter here only clears; the entry is empty so there is nothing to compare.
          if (key_valid) begin
            result_valid <= 1'b0;
            in_correct   <= 1'b0;
            ans_correct  <= 1'b0;
            hint         <= HINT_NONE;
            cnt          <= key_cnt;
            ovf          <= key_ovf;
            guess_bcd    <= key_bcd;
            state        <= ENTRY;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/guess_judge.md
# guess_judge

Game-logic stage that sits directly upstream of the dot-matrix result display in the guess-number design. It collects keypad digits into a two-digit guess, checks the entry format, and compares the guess against a secret answer drawn from an internal LFSR. It produces the `in_correct`/`ans_correct` pair that drives the display, plus a higher/lower hint and an attempt count.

## Interface
- `LFSR_SEED`, 8'hA5 — LFSR value loaded at reset; must be nonzero.
- `MAX_TRIES`, 7 — number of valid wrong guesses before lockout; used only with `GUESS_TRY_LIMIT_EN`.
- `clk_div` in 1 — single clock; every register is clocked on its rising edge.
- `rst` in 1 — synchronous, active-low reset.
- `new_game` in 1 — one-cycle pulse that starts or restarts a game.
- `preset_valid` in 1 — when high together with `new_game`, the answer is taken from `preset_ans` instead of the LFSR.
- `preset_ans` in 7 — forced answer; values above 99 are clamped to 99.
- `key_valid` in 1 — one-cycle key strobe.
- `key_code` in 4 — 0–9 are digits, 4'hA is clear, 4'hB is enter; 4'hC–4'hF are ignored.
- `in_correct` out 1 — the last submitted entry was well-formed.
- `ans_correct` out 1 — the last well-formed guess equalled the answer.
- `result_valid` out 1 — `in_correct`, `ans_correct` and `hint` are meaningful.
- `hint` out 2 — 00 none, 01 guess too low, 10 guess too high.
- `guess_bcd` out 8 — live entry; tens digit in [7:4], ones digit in [3:0].
- `tries` out 4 — count of valid guesses; saturates at 15.
- `game_over` out 1 — try limit reached.

## Operation
- States:
  - IDLE: after reset; all keys ignored.
  - ENTRY: digits are being collected.
  - COMPARE: lasts one cycle.
  - RESULT: last result is held on the outputs.
  - WIN: game won.
  - LOCKED: only with the macro compiled in.
- `new_game`, from any state:
  - captures the answer, clears the digit count, overflow flag, `guess_bcd`, `tries`, all result outputs and `game_over`;
  - moves the FSM to ENTRY.
- Answer capture: current LFSR value reduced mod 100 using two conditional subtractions (≥200 → −200, then ≥100 → −100). The answer is stored as a 7-bit binary value.
- LFSR: 8-bit Fibonacci, taps 8, 6, 5, 4. It steps every cycle in every state. Only `rst` reseeds it; `new_game` does not.
- ENTRY, digit key:
  - count 0 → tens digit written, count = 1;
  - count 1 → ones digit written, count = 2;
  - count 2 → overflow flag set, `guess_bcd` unchanged.
- ENTRY, clear key: count = 0, overflow cleared, `guess_bcd` = 0.
- ENTRY, enter key: go to COMPARE. The entry is valid iff count == 2 and overflow == 0.
- COMPARE:
  - Guess value = tens×10 + ones.
  - Invalid entry: `in_correct` = 0, `ans_correct` = 0, `hint` = 00, `tries` unchanged.
  - Valid entry: `in_correct` = 1; `tries` increments (saturating at 15); `ans_correct` = (guess == answer); `hint` = 01 if guess < answer, 10 if guess > answer, 00 if equal.
  - Next state: WIN if correct, otherwise RESULT. `result_valid` = 1.
- RESULT, any key_valid:
  - clears `result_valid`, `in_correct`, `ans_correct` and `hint`;
  - clears the count, overflow and `guess_bcd`;
  - processes the key as in ENTRY in the same cycle, and the FSM enters ENTRY.
- WIN: outputs are held, keys are ignored, and only `new_game` exits.
- `new_game` and `key_valid` in the same cycle: `new_game` wins and the key is dropped.
- `rst` low at any edge: returns the FSM to IDLE mid-operation. Every output is forced to 0: `in_correct`, `ans_correct`, `result_valid`, `hint`, `guess_bcd`, `tries`, `game_over`.

## Timing
- Enter key sampled at edge N → COMPARE during cycle N→N+1 → results and `result_valid` registered at edge N+1 and visible after it.
- A digit key sampled at edge N updates `guess_bcd` after edge N.
- `new_game` sampled at edge N: the answer and all cleared outputs are in effect after edge N.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `GUESS_TRY_LIMIT_EN` defined:
  - In COMPARE, a valid wrong guess that makes `tries` == `MAX_TRIES` goes to LOCKED instead of RESULT.
  - `game_over` = 1 from the same edge as `result_valid`.
  - LOCKED ignores keys; only `new_game` exits.
- `GUESS_TRY_LIMIT_EN` undefined: `game_over` is tied to 0, LOCKED does not exist, and `MAX_TRIES` is unused.

## Structure
- Package `guess_pkg` holds:
  - the state enum;
  - key-code constants (KEY_CLEAR = 4'hA, KEY_ENTER = 4'hB);
  - the hint encodings (HINT_NONE, HINT_LOW, HINT_HIGH).
- Sub-module `guess_lfsr` contains the 8-bit LFSR, with parameter `SEED`, synchronous active-low reset, and an 8-bit state output.

## Test plan
- Preset answer: `new_game` with `preset_valid`=1, `preset_ans`=42; keys 3, 7, enter → `in_correct`=1, `ans_correct`=0, `hint`=01, `tries`=1, `result_valid` high exactly 1 edge after enter is sampled.
- Same game, keys 4, 2, enter → `ans_correct`=1, `hint`=00, `tries`=2, state WIN; a further key 5 leaves `guess_bcd`=8'h42.
- Format errors with answer 42:
  - keys 5, enter → `in_correct`=0 and `tries` unchanged;
  - keys 1, 2, 3, enter → `in_correct`=0 (overflow);
  - keys 1, clear, 9, 9, enter → `in_correct`=1, `hint`=10.
- Answer bounds: `preset_ans`=120 → answer 99; reset then `new_game` with `preset_valid`=0 one cycle later → answer = (LFSR value after 1 step from 8'hA5) mod 100, checked against a bench model.
- `rst` low during COMPARE → all outputs 0 and state IDLE; `new_game` together with key 7 → key dropped, `guess_bcd`=0.
- With `GUESS_TRY_LIMIT_EN`, `MAX_TRIES`=3, answer 10: three guesses of 50 → third gives `game_over`=1; later keys are ignored; `new_game` clears `game_over` and `tries`.
